// File: rtl/flp_pkg.sv
// Shared types and helpers for the pipelined floating-point adder/subtractor.
package flp_pkg;

    localparam int EXP_W_DEF  = 8;
    localparam int FRAC_W_DEF = 23;
    localparam int EXP_MAX    = 11;
    localparam int FRAC_MAX   = 52;
    localparam int MANT_MAX   = FRAC_MAX + 1;

    typedef struct packed {
        logic                sign;
        logic [EXP_MAX-1:0]  exp;
        logic [MANT_MAX-1:0] mant;
        logic                is_zero;
        logic                is_inf;
        logic                is_nan;
    } flp_op_t;

    function automatic int data_w(input int ew, input int fw);
        return 1 + ew + fw;
    endfunction

    // hidden bit + fraction + guard/round/sticky
    function automatic int work_w(input int fw);
        return fw + 4;
    endfunction

    function automatic logic [63:0] canon_nan(input int ew, input int fw);
        logic [63:0] e_ones;
        e_ones = (64'd1 << ew) - 64'd1;
        return (e_ones << fw) | (64'd1 << (fw - 1));
    endfunction

    function automatic logic rnd_inc(
        input logic lsb,
        input logic g,
        input logic r,
        input logic s
    );
        return g & (r | s | lsb);
    endfunction

endpackage

// File: rtl/flp_lzc.sv
// Leading-zero counter; an all-zero input reports W.
module flp_lzc #(
    parameter  int W  = 27,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  x,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (x[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/flp_addsub_pipe.sv
// Pipelined floating-point add/sub with valid/ready flow control.
module flp_addsub_pipe
    import flp_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    input  logic                    sub,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   d,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    flag_ovf,
    output logic                    flag_unf,
    output logic                    flag_nv
);

    localparam int DW = data_w(EXP_W, FRAC_W);
    localparam int WW = work_w(FRAC_W);
    localparam int LW = $clog2(WW + 1);
    localparam logic [EXP_W-1:0] E_ONES = '1;
    localparam logic [DW-1:0]    QNAN   = DW'(canon_nan(EXP_W, FRAC_W));

    typedef struct packed {
        logic [DW-1:0]    d;
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic             unf;
        logic             nv;
    } res_t;

    function automatic flp_op_t unpack(input logic [DW-1:0] v, input logic flip);
        flp_op_t          o;
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        e         = v[DW-2:FRAC_W];
        f         = v[FRAC_W-1:0];
        o.sign    = v[DW-1] ^ flip;
        o.exp     = EXP_MAX'(e);
        o.is_zero = (e == '0);
        o.is_inf  = (e == E_ONES) && (f == '0);
        o.is_nan  = (e == E_ONES) && (f != '0);
        o.mant    = o.is_zero ? '0 : MANT_MAX'({1'b1, f});
        return o;
    endfunction

    flp_op_t           ua, ub, ox, oy;
    logic [EXP_W-1:0]  ex, ey, diff;
    logic [WW-1:0]     xa, ym, ya, mask;
    logic [WW:0]       sum;
    logic [LW-1:0]     lz;
    logic              eff_sub;
    int                sh;

    always_comb begin
        ua      = unpack(a, 1'b0);
        ub      = unpack(b, sub);
        ox      = ua;
        oy      = ub;
        if ({ub.exp, ub.mant} > {ua.exp, ua.mant}) begin
            ox = ub;
            oy = ua;
        end
        ex      = ox.exp[EXP_W-1:0];
        ey      = oy.exp[EXP_W-1:0];
        diff    = ex - ey;
        sh      = (int'(diff) > WW - 1) ? WW - 1 : int'(diff);
        xa      = {ox.mant[FRAC_W:0], 3'b000};
        ym      = {oy.mant[FRAC_W:0], 3'b000};
        mask    = ~({WW{1'b1}} << sh);
        ya      = (ym >> sh) | WW'(|(ym & mask));
        eff_sub = ox.sign ^ oy.sign;
        sum     = eff_sub ? {1'b0, xa} - {1'b0, ya}
                          : {1'b0, xa} + {1'b0, ya};
    end

    flp_lzc #(.W(WW)) u_lzc (
        .x   (sum[WW-1:0]),
        .cnt (lz)
    );

    logic [WW-1:0]     nm;
    logic [FRAC_W+1:0] mr;
    logic              inc;
    int                en, ef;
    res_t              res_c;

    always_comb begin
        if (sum[WW]) begin
            nm = sum[WW:1] | WW'(sum[0]);
            en = int'(ex) + 1;
        end else begin
            nm = sum[WW-1:0] << lz;
            en = int'(ex) - int'(lz);
        end
        inc = rnd_inc(nm[3], nm[2], nm[1], nm[0]);
        mr  = {1'b0, nm[WW-1:3]} + (FRAC_W+2)'(inc);
        ef  = en + int'(mr[FRAC_W+1]);

        res_c     = '0;
        res_c.tag = in_tag;
        if (ua.is_nan || ub.is_nan ||
            (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
            res_c.d  = QNAN;
            res_c.nv = 1'b1;
        end else if (ua.is_inf || ub.is_inf) begin
            res_c.d = {ua.is_inf ? ua.sign : ub.sign, E_ONES, FRAC_W'(0)};
        end else if (ua.is_zero && ub.is_zero) begin
            res_c.d = {ua.sign & ub.sign, (DW-1)'(0)};
        end else if (sum == '0) begin
            res_c.d = '0;
        end else if (ef >= int'(E_ONES)) begin
            res_c.d   = {ox.sign, E_ONES, FRAC_W'(0)};
            res_c.ovf = 1'b1;
        end else if (ef < 1) begin
            res_c.d   = {ox.sign, (DW-1)'(0)};
            res_c.unf = 1'b1;
        end else begin
            res_c.d = {ox.sign, EXP_W'(ef), mr[FRAC_W-1:0]};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ox, oy, mr[FRAC_W]};

    // global stall: every stage moves only when the output slot frees up
    logic advance;
    logic vq [STAGES];
    res_t rq [STAGES];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                vq[i] <= 1'b0;
                rq[i] <= '0;
            end
        end else if (advance) begin
            vq[0] <= in_valid;
            rq[0] <= in_valid ? res_c : '0;
            for (int i = 1; i < STAGES; i++) begin
                vq[i] <= vq[i-1];
                rq[i] <= rq[i-1];
            end
        end
    end

    assign out_valid = vq[STAGES-1];
    assign d         = rq[STAGES-1].d;
    assign out_tag   = rq[STAGES-1].tag;
    assign flag_ovf  = rq[STAGES-1].ovf;
    assign flag_unf  = rq[STAGES-1].unf;
    assign flag_nv   = rq[STAGES-1].nv;

endmodule
